conv_pool_mc: RTL and testbench

- Parametrised multi-channel 3x3 convolution plus 2x2 pooling engine; successor to the fixed three-kernel conv_pool.
- Streams 4x4 pixel tiles from an image memory.
- Convolves each tile with NUM_CH signed 3x3 kernels, giving a 2x2 result per channel.
- Applies a per-channel arithmetic shift, max-pools to one value, saturates, and writes one PIX_W result per channel per tile.
- Adds start/busy/done control and a programmable tile count.

---
 rtl/conv_pool_mc_pkg.sv | 22 ++
 rtl/conv_pool_ch.sv | 108 ++++++++++
 rtl/conv_pool_mc.sv | 137 +++++++++++++
 tb/tb_conv_pool_mc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pool_mc_pkg.sv
// Shared constants, FSM state encoding and width helper for conv_pool_mc.
// No logic, so no latency.
// No flow control in this file.
package conv_pool_mc_pkg;

  localparam int TILE_PIX = 16;
  localparam int NUM_TAPS = 9;
  localparam int POOL_N   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Enough headroom for nine full-scale signed products plus sign.
  function automatic int acc_width(input int pix_w, input int w_w);
    return pix_w + w_w + 5;
  endfunction

endpackage

// File: rtl/conv_pool_ch.sv
// One output channel: 3x3 conv over a 4x4 tile, shift, 2x2 pool, clamp.
// Three register stages: products, sums, result (result loads only on i_load).
// No backpressure; the tile stream is gap-free and the pipeline never stalls.
// Macro CONV_POOL_MC_AVG_POOL_EN adds the average-pooling select.
module conv_pool_ch
  import conv_pool_mc_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int W_W     = 8,
  parameter int SHIFT_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TILE_PIX*PIX_W-1:0]   i_image,
  input  logic [NUM_TAPS*W_W-1:0]     i_kernel,
  input  logic [SHIFT_W-1:0]          i_shift,
`ifdef CONV_POOL_MC_AVG_POOL_EN
  input  logic                        i_pool_mode,
`endif
  input  logic                        i_load,
  output logic [PIX_W-1:0]            o_y
);

  localparam int PROD_W = PIX_W + W_W + 1;
  localparam int ACC_W  = acc_width(PIX_W, W_W);
  localparam int POOL_W = ACC_W + 2;
  localparam logic signed [POOL_W-1:0] MAXV = POOL_W'((1 << PIX_W) - 1);

  logic signed [PROD_W-1:0] w_prod [POOL_N][NUM_TAPS];
  logic signed [PROD_W-1:0] r_prod [POOL_N][NUM_TAPS];
  logic signed [ACC_W-1:0]  w_sum  [POOL_N];
  logic signed [ACC_W-1:0]  r_sum  [POOL_N];
  logic signed [ACC_W-1:0]  w_sh   [POOL_N];
  logic signed [ACC_W-1:0]  w_max;
  logic signed [POOL_W-1:0] w_tot;
  logic signed [POOL_W-1:0] w_pool;
  logic [PIX_W-1:0]         w_clamp;
  logic [PIX_W-1:0]         r_y;

  // Products: output o=(i,j) uses pixel (i+r, j+c) against tap (r,c); pixels zero-extended.
  always_comb begin
    for (int o = 0; o < POOL_N; o++) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        w_prod[o][k] =
          PROD_W'($signed({1'b0, i_image[((o/2 + k/3)*4 + (o%2) + (k%3))*PIX_W +: PIX_W]})) *
          PROD_W'($signed(i_kernel[k*W_W +: W_W]));
      end
    end
  end

  // Adder tree for each of the four conv outputs.
  always_comb begin
    for (int o = 0; o < POOL_N; o++) begin
      w_sum[o] = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        w_sum[o] = w_sum[o] + ACC_W'(r_prod[o][k]);
      end
    end
  end

  // Floor shift, then max or average pool, then clamp to the unsigned pixel range.
  always_comb begin
    w_max = '0;
    w_tot = '0;
    for (int o = 0; o < POOL_N; o++) begin
      w_sh[o] = r_sum[o] >>> i_shift;
      if (o == 0 || w_sh[o] > w_max) begin
        w_max = w_sh[o];
      end
      w_tot = w_tot + POOL_W'(w_sh[o]);
    end
    w_pool = POOL_W'(w_max);
`ifdef CONV_POOL_MC_AVG_POOL_EN
    if (i_pool_mode) begin
      w_pool = w_tot >>> 2;
    end
`endif
    if (w_pool[POOL_W-1]) begin
      w_clamp = '0;
    end else if (w_pool > MAXV) begin
      w_clamp = '1;
    end else begin
      w_clamp = w_pool[PIX_W-1:0];
    end
  end

  // Pipeline registers; the result holds between loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < POOL_N; o++) begin
        r_sum[o] <= '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
          r_prod[o][k] <= '0;
        end
      end
      r_y <= '0;
    end else begin
      r_prod <= w_prod;
      r_sum  <= w_sum;
      if (i_load) begin
        r_y <= w_clamp;
      end
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/conv_pool_mc.sv
// Multi-channel 3x3 conv + 2x2 pool engine with start/busy/done and tile count.
// Read at cycle t -> output_we/output_addr/y at t+4; done the cycle after the last write.
// No backpressure: reads are issued every cycle while fetching. Macro CONV_POOL_MC_AVG_POOL_EN adds pool_mode.
module conv_pool_mc
  import conv_pool_mc_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int PIX_W   = 8,
  parameter int W_W     = 8,
  parameter int ADDR_W  = 16,
  parameter int SHIFT_W = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             last_addr,
  input  logic [TILE_PIX*PIX_W-1:0]     image_4x4,
  input  logic [NUM_CH*NUM_TAPS*W_W-1:0] conv_kernel,
  input  logic [NUM_CH*SHIFT_W-1:0]     shift,
`ifdef CONV_POOL_MC_AVG_POOL_EN
  input  logic                          pool_mode,
`endif
  output logic                          input_re,
  output logic [ADDR_W-1:0]             input_addr,
  output logic                          output_we,
  output logic [ADDR_W-1:0]             output_addr,
  output logic [NUM_CH*PIX_W-1:0]       y,
  output logic                          busy,
  output logic                          done
);

  state_t                         r_state;
  state_t                         w_next;
  logic [ADDR_W-1:0]              r_addr;
  logic [ADDR_W-1:0]              r_last;
  logic [NUM_CH*NUM_TAPS*W_W-1:0] r_kernel;
  logic [NUM_CH*SHIFT_W-1:0]      r_shift;
`ifdef CONV_POOL_MC_AVG_POOL_EN
  logic                           r_pool_mode;
`endif
  // r_vld[0]: tile data on image_4x4, [1]: products, [2]: sums, [3]: result on y.
  logic [3:0]                     r_vld;
  logic [ADDR_W-1:0]              r_apipe [4];
  logic                           w_accept;

  assign w_accept = (r_state == IDLE) && start;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state: drain until only the final result remains on the output register.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = FETCH;
      FETCH:   if (r_addr == r_last) w_next = DRAIN;
      DRAIN:   if (r_vld[2:0] == 3'b000) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Address counter stops at the last tile, so a full-space run never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= '0;
    end else if (r_state == FETCH && r_addr != r_last) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  // Config latched on an accepted start only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last   <= '0;
      r_kernel <= '0;
      r_shift  <= '0;
`ifdef CONV_POOL_MC_AVG_POOL_EN
      r_pool_mode <= 1'b0;
`endif
    end else if (w_accept) begin
      r_last   <= last_addr;
      r_kernel <= conv_kernel;
      r_shift  <= shift;
`ifdef CONV_POOL_MC_AVG_POOL_EN
      r_pool_mode <= pool_mode;
`endif
    end
  end

  // Valid and address tracking alongside the datapath stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < 4; i++) r_apipe[i] <= '0;
    end else begin
      r_vld      <= {r_vld[2:0], input_re};
      r_apipe[0] <= input_addr;
      for (int i = 1; i < 4; i++) r_apipe[i] <= r_apipe[i-1];
    end
  end

  genvar ch;
  generate
    for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
      conv_pool_ch #(
        .PIX_W   (PIX_W),
        .W_W     (W_W),
        .SHIFT_W (SHIFT_W)
      ) u_ch (
        .clk         (clk),
        .rst         (rst),
        .i_image     (image_4x4),
        .i_kernel    (r_kernel[ch*NUM_TAPS*W_W +: NUM_TAPS*W_W]),
        .i_shift     (r_shift[ch*SHIFT_W +: SHIFT_W]),
`ifdef CONV_POOL_MC_AVG_POOL_EN
        .i_pool_mode (r_pool_mode),
`endif
        .i_load      (r_vld[2]),
        .o_y         (y[ch*PIX_W +: PIX_W])
      );
    end
  endgenerate

  assign input_re    = (r_state == FETCH);
  assign input_addr  = r_addr;
  assign output_we   = r_vld[3];
  assign output_addr = r_apipe[3];
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);

endmodule

// File: tb/tb_conv_pool_mc.sv
module tb_conv_pool_mc;
  localparam int NUM_CH = 3, PIX_W = 8, W_W = 8, ADDR_W = 16, SHIFT_W = 2;
  localparam int YW = NUM_CH*PIX_W;

  logic clk, rst, start;
  logic [ADDR_W-1:0] last_addr;
  logic [16*PIX_W-1:0] image_4x4;
  logic [NUM_CH*9*W_W-1:0] conv_kernel;
  logic [NUM_CH*SHIFT_W-1:0] shift;
`ifdef CONV_POOL_MC_AVG_POOL_EN
  logic pool_mode;
`endif
  logic input_re, output_we, busy, done;
  logic [ADDR_W-1:0] input_addr, output_addr;
  logic [YW-1:0] y;

  conv_pool_mc #(.NUM_CH(NUM_CH), .PIX_W(PIX_W), .W_W(W_W), .ADDR_W(ADDR_W), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .last_addr(last_addr), .image_4x4(image_4x4),
    .conv_kernel(conv_kernel), .shift(shift),
`ifdef CONV_POOL_MC_AVG_POOL_EN
    .pool_mode(pool_mode),
`endif
    .input_re(input_re), .input_addr(input_addr), .output_we(output_we),
    .output_addr(output_addr), .y(y), .busy(busy), .done(done));

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [YW-1:0] last_y;

  // model configuration (what the DUT should have latched)
  int k_m [NUM_CH*9];
  int sh_m [NUM_CH];
  int pm_m = 0;
  int pat = 0, cval = 0;
  logic [31:0] seed = 32'h1234_5678;

  typedef struct { int cyc; int addr; logic [YW-1:0] y; } exp_t;
  exp_t q[$];
  exp_t e_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pix(input int a, input int idx);
    logic [31:0] h;
    case (pat)
      0: return idx*10;
      1: return cval;
      default: begin
        h = (32'(a) * 32'h9E3779B1) ^ (32'(idx + 1) * 32'h85EBCA6B) ^ seed;
        h = h ^ (h >> 15);
        h = h * 32'h2C1B3C6D;
        return int'(h[23:16]);
      end
    endcase
  endfunction

  function automatic int fdiv(input int v, input int d);
    int qq;
    qq = v / d;
    if ((v % d) != 0 && v < 0) qq = qq - 1;
    return qq;
  endfunction

  // Reference: direct arithmetic from the conv/pool definition.
  function automatic logic [YW-1:0] model(input int a);
    logic [YW-1:0] res;
    int p [16];
    int s, v, best, tot, pooled;
    res = '0;
    for (int idx = 0; idx < 16; idx++) p[idx] = pix(a, idx);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      best = 0; tot = 0;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          s = 0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              s += k_m[ch*9 + r*3 + c] * p[(i+r)*4 + j + c];
          v = fdiv(s, 1 << sh_m[ch]);
          if ((i == 0 && j == 0) || v > best) best = v;
          tot += v;
        end
      pooled = (pm_m != 0) ? fdiv(tot, 4) : best;
      if (pooled < 0) pooled = 0;
      if (pooled > 255) pooled = 255;
      res[ch*PIX_W +: PIX_W] = PIX_W'(pooled);
    end
    return res;
  endfunction

  always @(posedge clk) cyc++;

  // Image memory: data appears one cycle after the read.
  logic pend_re;
  int pend_addr;
  always @(negedge clk) begin
    pend_re = input_re;
    pend_addr = int'(input_addr);
  end
  always @(posedge clk) begin
    #1;
    if (pend_re) for (int idx = 0; idx < 16; idx++) image_4x4[idx*PIX_W +: PIX_W] = PIX_W'(pix(pend_addr, idx));
  end

  // Scoreboard: push on read, pop/compare on write.
  always @(negedge clk) begin
    if (!rst && input_re) q.push_back('{cyc + 4, int'(input_addr), model(int'(input_addr))});
    if (!rst && output_we) begin
      if (q.size() == 0) begin
        chk("unexpected_we", 64'(output_addr), 64'hDEAD);
      end else begin
        e_pop = q.pop_front();
        chk("out_addr", 64'(output_addr), 64'(e_pop.addr));
        chk("out_y", 64'(y), 64'(e_pop.y));
        chk("out_latency", 64'(cyc), 64'(e_pop.cyc));
      end
      last_y = y;
    end
    if (done) done_cnt++;
  end

  task automatic drive_cfg();
    for (int i = 0; i < NUM_CH*9; i++) conv_kernel[i*W_W +: W_W] = W_W'(k_m[i]);
    for (int c = 0; c < NUM_CH; c++) shift[c*SHIFT_W +: SHIFT_W] = SHIFT_W'(sh_m[c]);
`ifdef CONV_POOL_MC_AVG_POOL_EN
    pool_mode = (pm_m != 0);
`endif
  endtask

  task automatic set_kern(input int v);
    for (int i = 0; i < NUM_CH*9; i++) k_m[i] = v;
  endtask

  task automatic rand_cfg();
    logic [7:0] b;
    for (int i = 0; i < NUM_CH*9; i++) begin b = 8'($urandom); k_m[i] = int'($signed(b)); end
    for (int c = 0; c < NUM_CH; c++) sh_m[c] = $urandom_range(0, 3);
    seed = $urandom;
  endtask

  task automatic run(input int last, input int budget, input string name);
    int n;
    done_cnt = 0;
    @(posedge clk); #1;
    drive_cfg();
    last_addr = ADDR_W'(last);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
    chk({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
    chk({name, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({name, "_queue_empty"}, 64'(q.size()), 64'd0);
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1; start = 0; last_addr = '0; image_4x4 = '0; conv_kernel = '0; shift = '0;
`ifdef CONV_POOL_MC_AVG_POOL_EN
    pool_mode = 0;
`endif
    for (int c = 0; c < NUM_CH; c++) sh_m[c] = 0;
    set_kern(0);
    repeat (3) @(negedge clk);
    chk("rst_re", 64'(input_re), 0);
    chk("rst_iaddr", 64'(input_addr), 0);
    chk("rst_we", 64'(output_we), 0);
    chk("rst_oaddr", 64'(output_addr), 0);
    chk("rst_y", 64'(y), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    @(posedge clk); #1; rst = 0;

    // Centre tap only, ramp tile: max(50,60,90,100)
    set_kern(0); for (int c = 0; c < NUM_CH; c++) k_m[c*9 + 4] = 1;
    pat = 0;
    run(0, 50, "center");
    chk("center_y", 64'(last_y), 64'({NUM_CH{8'd100}}));

    // All -1 weights, white tile -> negative -> 0
    set_kern(-1); pat = 1; cval = 255;
    run(1, 50, "neg");
    chk("neg_y", 64'(last_y), 0);

    // All 127 weights, white tile -> saturate
    set_kern(127);
    run(1, 50, "sat");
    chk("sat_y", 64'(last_y), 64'({NUM_CH{8'd255}}));

    // Sum 36 with shifts 2,3,0 -> 9,4,36
    set_kern(1); cval = 4; sh_m[0] = 2; sh_m[1] = 3; sh_m[2] = 0;
    run(2, 50, "shift");
    chk("shift_y", 64'(last_y), 64'({8'd36, 8'd4, 8'd9}));
`ifdef CONV_POOL_MC_AVG_POOL_EN
    pm_m = 1;
    run(2, 50, "avg_const");
    chk("avg_const_y", 64'(last_y), 64'({8'd36, 8'd4, 8'd9}));
    rand_cfg(); pat = 2;
    run(7, 60, "avg_rand");
    pm_m = 0;
`endif

    // Cycle-accurate control timing; second start at cycle 3 must be ignored.
    rand_cfg(); pat = 2; done_cnt = 0;
    @(posedge clk); #1;
    drive_cfg(); last_addr = 3; start = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("tim_re_c%0d", c), 64'(input_re), 64'(c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) chk($sformatf("tim_iaddr_c%0d", c), 64'(input_addr), 64'(c - 1));
      chk($sformatf("tim_we_c%0d", c), 64'(output_we), 64'(c >= 5 && c <= 8));
      chk($sformatf("tim_busy_c%0d", c), 64'(busy), 64'(c >= 1 && c <= 9));
      chk($sformatf("tim_done_c%0d", c), 64'(done), 64'(c == 9));
      @(posedge clk); #1;
      start = (c + 1 == 3);
      if (c + 1 == 3) begin last_addr = 10; conv_kernel = ~conv_kernel; shift = ~shift; end
    end
    chk("tim_done_once", 64'(done_cnt), 1);
    chk("tim_queue_empty", 64'(q.size()), 0);

    // Reset mid-run at cycle 6
    set_kern(0); for (int c = 0; c < NUM_CH; c++) begin k_m[c*9 + 4] = 1; sh_m[c] = 0; end
    pat = 0; done_cnt = 0;
    @(posedge clk); #1;
    drive_cfg(); last_addr = 3; start = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 7) begin
        chk($sformatf("mrst_re_c%0d", c), 64'(input_re), 0);
        chk($sformatf("mrst_iaddr_c%0d", c), 64'(input_addr), 0);
        chk($sformatf("mrst_we_c%0d", c), 64'(output_we), 0);
        chk($sformatf("mrst_oaddr_c%0d", c), 64'(output_addr), 0);
        chk($sformatf("mrst_y_c%0d", c), 64'(y), 0);
        chk($sformatf("mrst_busy_c%0d", c), 64'(busy), 0);
        chk($sformatf("mrst_done_c%0d", c), 64'(done), 0);
      end
      @(posedge clk); #1;
      start = 0;
      rst = (c + 1 == 6);
      if (c + 1 == 7) q.delete();
    end
    chk("mrst_no_done", 64'(done_cnt), 0);
    rand_cfg(); pat = 2;
    run(2, 50, "after_rst");

    // Random short runs, including a single tile
    for (int r = 0; r < 5; r++) begin
      rand_cfg(); pat = 2;
      run((r == 0) ? 0 : $urandom_range(1, 20), 80, $sformatf("rnd%0d", r));
    end

    // Full address space
    rand_cfg(); pat = 2;
    run(65535, 70000, "full");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
